// File: rtl/endpay_seq_display.sv
// endpay_seq_display: end-of-transaction sequencer that alternates message and change
// pages on a multiplexed seven-segment display, then raises out_endpay.
`default_nettype none

module endpay_seq_display #(
  parameter int DIGITS     = 8,
  parameter int SCAN_DIV   = 12500,
  parameter int DWELL      = 12000,
  parameter int REPEAT     = 4,
  parameter int ACTIVE_LOW = 1
) (
  input  logic              clk,
  input  logic              EN,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [3:0]        returnone,
  input  logic [3:0]        returnten,
  output logic [DIGITS-1:0] seg_en,
  output logic [7:0]        seg_out,
  output logic              busy,
  output logic              out_endpay
);

  localparam int DIV_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DWL_W  = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int SCAN_W = $clog2(DIGITS);

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SCAN_DIV - 1);
  localparam logic [DWL_W-1:0]  DWL_LAST  = DWL_W'(DWELL - 1);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(DIGITS - 1);
  localparam logic [7:0]        PAGE_LAST = 8'(REPEAT - 1);

  // XOR masks: inactive pattern at the pins, also used to invert active values.
  localparam logic [DIGITS-1:0] EN_OFF  = {DIGITS{ACTIVE_LOW != 0}};
  localparam logic [7:0]        SEG_OFF = {8{ACTIVE_LOW != 0}};
  localparam logic [DIGITS-1:0] ONE_HOT = {{(DIGITS-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_IDLE, S_SHOW, S_DONE} state_t;

  state_t             state_q;
  logic [DIV_W-1:0]   div_q;
  logic [DWL_W-1:0]   dwell_q;
  logic [SCAN_W-1:0]  scan_q;
  logic [7:0]         page_q;
  logic [1:0]         mode_q;
  logic [3:0]         one_q;
  logic [3:0]         ten_q;
  logic [DIGITS-1:0]  seg_en_q;
  logic [7:0]         seg_out_q;
  logic               busy_q;
  logic               endpay_q;

  logic               tick;
  logic               show_change;
  logic [7:0]         glyph_d;

  function automatic logic [7:0] bcd_seg(input logic [3:0] v);
    logic [7:0] s;
    case (v)
      4'd0:    s = 8'h3F;
      4'd1:    s = 8'h06;
      4'd2:    s = 8'h5B;
      4'd3:    s = 8'h4F;
      4'd4:    s = 8'h66;
      4'd5:    s = 8'h6D;
      4'd6:    s = 8'h7D;
      4'd7:    s = 8'h07;
      4'd8:    s = 8'h7F;
      4'd9:    s = 8'h6F;
      default: s = 8'h40;
    endcase
    return s;
  endfunction

  assign tick        = (div_q == DIV_LAST);
  // Mode 2 always shows change; a zero change never shows a change page otherwise.
  assign show_change = (mode_q == 2'd2) ||
                       (((ten_q != 4'd0) || (one_q != 4'd0)) && page_q[0]);

  always_comb begin
    glyph_d = 8'h00;
    if (show_change) begin
      case (4'(scan_q))
        4'd7: glyph_d = 8'h39;
        4'd6: glyph_d = 8'h76;
        4'd5: glyph_d = 8'h77;
        4'd4: glyph_d = 8'h37;
        4'd3: glyph_d = 8'h6F;
        4'd2: glyph_d = 8'hF9;
        4'd1: glyph_d = bcd_seg(ten_q);
        4'd0: glyph_d = bcd_seg(one_q);
        default: glyph_d = 8'h00;
      endcase
    end else if (mode_q[0]) begin
      case (4'(scan_q))
        4'd7: glyph_d = 8'h71;
        4'd6: glyph_d = 8'h77;
        4'd5: glyph_d = 8'h30;
        4'd4: glyph_d = 8'h38;
        default: glyph_d = 8'h00;
      endcase
    end else begin
      case (4'(scan_q))
        4'd7: glyph_d = 8'h6D;
        4'd6: glyph_d = 8'h3E;
        4'd5: glyph_d = 8'h39;
        4'd4: glyph_d = 8'h39;
        4'd3: glyph_d = 8'h79;
        4'd2: glyph_d = 8'h79;
        4'd1: glyph_d = 8'h5E;
        default: glyph_d = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk or negedge EN) begin
    if (!EN) begin
      state_q   <= S_IDLE;
      div_q     <= '0;
      dwell_q   <= '0;
      scan_q    <= '0;
      page_q    <= '0;
      mode_q    <= '0;
      one_q     <= '0;
      ten_q     <= '0;
      seg_en_q  <= EN_OFF;
      seg_out_q <= SEG_OFF;
      busy_q    <= 1'b0;
      endpay_q  <= 1'b0;
    end else begin
      case (state_q)
        S_SHOW: begin
          seg_en_q  <= EN_OFF ^ (ONE_HOT << scan_q);
          seg_out_q <= SEG_OFF ^ glyph_d;
          if (tick) begin
            div_q  <= '0;
            scan_q <= (scan_q == SCAN_LAST) ? '0 : scan_q + 1'b1;
            if (dwell_q == DWL_LAST) begin
              dwell_q <= '0;
              page_q  <= page_q + 8'd1;
              if (page_q == PAGE_LAST) begin
                state_q   <= S_DONE;
                busy_q    <= 1'b0;
                endpay_q  <= 1'b1;
                seg_en_q  <= EN_OFF;
                seg_out_q <= SEG_OFF;
              end
            end else begin
              dwell_q <= dwell_q + 1'b1;
            end
          end else begin
            div_q <= div_q + 1'b1;
          end
        end
        default: begin
          seg_en_q  <= EN_OFF;
          seg_out_q <= SEG_OFF;
          if (start) begin
            state_q  <= S_SHOW;
            div_q    <= '0;
            dwell_q  <= '0;
            scan_q   <= '0;
            page_q   <= '0;
            mode_q   <= mode;
            one_q    <= returnone;
            ten_q    <= returnten;
            busy_q   <= 1'b1;
            endpay_q <= 1'b0;
          end
        end
      endcase
    end
  end

  assign seg_en     = seg_en_q;
  assign seg_out    = seg_out_q;
  assign busy       = busy_q;
  assign out_endpay = endpay_q;

endmodule

`default_nettype wire

// File: tb/tb_endpay_seq_display.sv
// tb_endpay_seq_display: randomized runs on two configurations checked every cycle
// against a page/digit-text reference model.
`default_nettype none

module tb_endpay_seq_display;

  localparam int SD    = 2;
  localparam int DW    = 3;
  localparam int RP    = 4;
  localparam int TOTAL = SD * DW * RP;

  logic       clk = 1'b0;
  logic       EN = 1'b1;
  logic       start = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [3:0] returnone = 4'd0;
  logic [3:0] returnten = 4'd0;

  logic [7:0] en_a;
  logic [7:0] so_a;
  logic       busy_a, end_a;
  logic [3:0] en_b;
  logic [7:0] so_b;
  logic       busy_b, end_b;

  int checks = 0;
  int failures = 0;
  bit mon = 1'b0;

  int cyc = 0;
  int m_k = 0;
  bit m_run = 1'b0;
  bit m_done = 1'b0;
  int m_mode = 0, m_ten = 0, m_one = 0;

  logic [7:0] dig [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};

  endpay_seq_display #(.DIGITS(8), .SCAN_DIV(SD), .DWELL(DW), .REPEAT(RP), .ACTIVE_LOW(0)) u_a (
    .clk(clk), .EN(EN), .start(start), .mode(mode), .returnone(returnone), .returnten(returnten),
    .seg_en(en_a), .seg_out(so_a), .busy(busy_a), .out_endpay(end_a));

  endpay_seq_display #(.DIGITS(4), .SCAN_DIV(SD), .DWELL(DW), .REPEAT(RP), .ACTIVE_LOW(1)) u_b (
    .clk(clk), .EN(EN), .start(start), .mode(mode), .returnone(returnone), .returnten(returnten),
    .seg_en(en_b), .seg_out(so_b), .busy(busy_b), .out_endpay(end_b));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] char_seg(input byte c);
    case (c)
      "S": return 8'h6D;
      "U": return 8'h3E;
      "C": return 8'h39;
      "E": return 8'h79;
      "d": return 8'h5E;
      "F": return 8'h71;
      "A": return 8'h77;
      "I": return 8'h30;
      "L": return 8'h38;
      "H": return 8'h76;
      "n": return 8'h37;
      "G": return 8'h6F;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] num_seg(input int v);
    return (v < 10) ? dig[v] : 8'h40;
  endfunction

  // Page text is written left to right as digit 7 down to digit 0.
  function automatic logic [7:0] model_glyph(input int idx, input bit chg, input bit fail);
    string s;
    if (idx > 7) return 8'h00;
    if (chg) begin
      if (idx == 1) return num_seg(m_ten);
      if (idx == 0) return num_seg(m_one);
      s = "CHAnGE";
      return char_seg(s[7-idx]) | ((idx == 2) ? 8'h80 : 8'h00);
    end
    s = fail ? "FAIL    " : "SUCCEEd ";
    return char_seg(s[7-idx]);
  endfunction

  function automatic void model_out(input int D, input bit AL,
                                    output logic [15:0] e_en, output logic [7:0] e_so);
    int n, m, idx, pg;
    bit chg;
    e_en = 16'h0;
    e_so = 8'h00;
    if (m_run) begin
      n = cyc - m_k;
      if (n >= 1) begin
        m   = n - 1;
        idx = (m / SD) % D;
        pg  = m / (SD * DW);
        chg = (m_mode == 2) || (((m_ten != 0) || (m_one != 0)) && (pg % 2 == 1));
        e_en = 16'(1) << idx;
        e_so = model_glyph(idx, chg, (m_mode == 1) || (m_mode == 3));
      end
    end
    if (AL) begin
      e_en = e_en ^ ((16'(1) << D) - 16'(1));
      e_so = e_so ^ 8'hFF;
    end
  endfunction

  always @(posedge clk or negedge EN) begin
    if (!EN) begin
      m_run  = 1'b0;
      m_done = 1'b0;
    end else begin
      cyc++;
      if (m_run) begin
        if (cyc - m_k == TOTAL) begin
          m_run  = 1'b0;
          m_done = 1'b1;
        end
      end else if (start) begin
        m_run  = 1'b1;
        m_done = 1'b0;
        m_k    = cyc;
        m_mode = int'(mode);
        m_ten  = int'(returnten);
        m_one  = int'(returnone);
      end
    end
  end

  logic [15:0] ea, eb;
  logic [7:0]  sa, sb;

  always @(negedge clk) begin
    if (mon) begin
      model_out(8, 1'b0, ea, sa);
      model_out(4, 1'b1, eb, sb);
      check("a_seg_en", 32'(en_a), 32'(ea[7:0]));
      check("a_seg_out", 32'(so_a), 32'(sa));
      check("a_busy", 32'(busy_a), 32'(m_run));
      check("a_endpay", 32'(end_a), 32'(m_done));
      check("b_seg_en", 32'(en_b), 32'(eb[3:0]));
      check("b_seg_out", 32'(so_b), 32'(sb));
      check("b_busy", 32'(busy_b), 32'(m_run));
      check("b_endpay", 32'(end_b), 32'(m_done));
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_a_en"}, 32'(en_a), 32'h00);
    check({tag, "_a_so"}, 32'(so_a), 32'h00);
    check({tag, "_a_busy"}, 32'(busy_a), 32'h0);
    check({tag, "_a_end"}, 32'(end_a), 32'h0);
    check({tag, "_b_en"}, 32'(en_b), 32'hF);
    check({tag, "_b_so"}, 32'(so_b), 32'hFF);
    check({tag, "_b_busy"}, 32'(busy_b), 32'h0);
    check({tag, "_b_end"}, 32'(end_b), 32'h0);
  endtask

  task automatic run(input int md, input int tn, input int on, input bit noisy);
    @(negedge clk);
    mode = 2'(md); returnten = 4'(tn); returnone = 4'(on);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < TOTAL + 3; c++) begin
      @(negedge clk);
      if (noisy && c < TOTAL - 4) begin
        mode = 2'($urandom); returnten = 4'($urandom); returnone = 4'($urandom);
        start = ($urandom_range(0, 3) == 0);
      end else begin
        start = 1'b0;
      end
    end
  endtask

  initial begin
    #1 EN = 1'b0;
    #1 check_reset_outputs("rst_init");
    repeat (2) @(negedge clk);
    EN = 1'b1;
    mon = 1'b1;

    run(0, 2, 5, 1'b0);
    run(1, 0, 0, 1'b0);
    run(2, 12, 3, 1'b0);
    run(0, 0, 0, 1'b0);
    run(3, 9, 9, 1'b1);
    run(0, 2, 5, 1'b1);
    for (int i = 0; i < 6; i++)
      run(int'($urandom_range(0, 3)), int'($urandom_range(0, 15)),
          int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));

    // Asynchronous reset in the middle of a run, then a clean restart.
    @(negedge clk);
    mode = 2'd0; returnten = 4'd4; returnone = 4'd7;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    #2 EN = 1'b0;
    #1 check_reset_outputs("rst_async");
    repeat (2) @(negedge clk);
    EN = 1'b1;
    run(0, 4, 7, 1'b0);
    run(1, 1, 0, 1'b0);

    repeat (3) @(negedge clk);
    mon = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/endpay_seq_display.md
Name: endpay_seq_display

Overview:
- Parametrised end-of-transaction display sequencer for the vending-machine front panel.
- On a start request it latches the result mode and the change amount.
- It then alternates message and change pages on a multiplexed N-digit seven-segment display for a set number of dwell periods, then raises out_endpay and blanks the display.
- It sits between the payment controller, which drives start, mode and change, and the board seven-segment pins.

Parameters:
- DIGITS, 8: number of multiplexed digits; legal range 4..16.
- SCAN_DIV, 12500: clk cycles per digit scan step.
- DWELL, 12000: scan steps per page.
- REPEAT, 4: pages shown before completion; legal range 1..255.
- ACTIVE_LOW, 1: 1 inverts seg_en and seg_out at the pins.

Ports:
- clk  in  1  system clock.
- EN  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to begin a sequence.
- mode  in  2  result code: 0 success, 1 fail, 2 change-only, 3 treated as fail.
- returnone  in  4  change units digit, BCD.
- returnten  in  4  change tens digit, BCD.
- seg_en  out  DIGITS  digit enables, one-hot when active.
- seg_out  out  8  segments: bit7 dp, bits6..0 gfedcba.
- busy  out  1  high while a sequence runs.
- out_endpay  out  1  completion flag.

Behaviour:
- Reset (EN low, asynchronous):
  - Goes to state IDLE; all counters are 0.
  - busy=0, out_endpay=0.
  - seg_en and seg_out are inactive: all ones if ACTIVE_LOW=1, else all zeros.
- States: IDLE, SHOW, DONE.
- IDLE:
  - Display is inactive.
  - start=1 latches mode, returnone and returnten; clears the divider, scan index, dwell and page counters; goes to SHOW.
  - busy=1 from the next edge.
- SHOW, divider:
  - Counts 0..SCAN_DIV-1.
  - A tick occurs when the count equals SCAN_DIV-1.
- SHOW, scan index:
  - Advances on each tick and wraps DIGITS-1 -> 0.
- SHOW, dwell counter:
  - Counts ticks 0..DWELL-1.
  - On wrap, the page counter increments and the page toggles.
- SHOW, page selection:
  - Page 0 is the message page; pages alternate message/change.
  - Latched mode=2: every page is the change page.
  - Latched change = 00 and mode!=2: every page is the message page.
- SHOW, completion:
  - When the page counter reaches REPEAT, go to DONE.
  - This is exactly REPEAT*DWELL*SCAN_DIV clk cycles after the start edge.
  - At that edge: out_endpay=1, busy=0.
- DONE:
  - Display is inactive; out_endpay holds 1.
  - start=1 clears out_endpay and begins a new sequence, as from IDLE.
- start while busy is ignored; latched inputs never change mid-sequence.
- Mid-sequence reset returns to IDLE immediately with reset output values.
- Display outputs:
  - seg_en and seg_out are registered, one clk after the scan index changes.
  - Digit i drives seg_en bit i.
- Message page contents, digit 7 down to 0; unlisted digits are blank:
  - Success: S U C C E E d blank.
  - Fail: F A I L.
- Change page contents, digit 7 down to 0:
  - C H A n g E (with dp set), then tens, then units.
- Digits at index 8 and above are blank; with DIGITS<8 only digits 0..DIGITS-1 are shown.
- Segment codes, active-high before inversion:
  - S 6D, U 3E, C 39, E 79, d 5E, F 71, A 77, I 30, L 38, H 76, n 37, g 6F, blank 00.
  - Digits 0-9: 3F 06 5B 4F 66 6D 7D 07 7F 6F.
  - BCD 10..15 displays 40 (dash).

Test Plan:
1. Bench parameters for scenarios 1–5: SCAN_DIV=2, DWELL=3, REPEAT=4, DIGITS=8, ACTIVE_LOW=0. Stimulus: mode=0, change 25, start at edge k -> busy=1 from k+1. seg_en steps 01,02,04… every 2 clk. Page toggles every 6 clk: message then change. out_endpay=1 and busy=0 at edge k+24; display all zero afterwards.
2. Change page content -> digit0=6D ('5'), digit1=5B ('2'), digit2=F9 (E with dp), digit7=39.
3. mode=1, change 00 -> all 4 pages show FAIL: digit7=71, digit4=38, digits 3..0=00. out_endpay at k+24.
4. mode=2, returnten=12 -> change page only; digit1=40.
5. Change start inputs at k+5 and pulse start at k+10 -> no restart; latched values are displayed; completion stays at k+24. Then assert EN low at k+7 of a fresh run -> all outputs 0 asynchronously; after release, a start works normally.
6. ACTIVE_LOW=1, DIGITS=4 -> reset outputs seg_en=F, seg_out=FF. Scan wraps after 4 digits; only the last four digits of each page (digits 3..0) are visible.
